// File: rtl/mc_ctrl_if.sv
// Control/status bundle between mc_ctrl (master) and the MIPS-subset datapath (slave).
interface mc_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWr;
  logic [1:0] PCSrc;
  logic       IRWr;
  logic       MemWr;
  logic       RFWr;
  logic       RegDst;
  logic       WDSel;
  logic       BSel;
  logic [1:0] ExtOp;
  logic [1:0] ALUOp;
  logic       InsnDone;
  logic       Illegal;

  modport master (
    input  Op, Funct, Zero,
    output PCWr, PCSrc, IRWr, MemWr, RFWr, RegDst, WDSel, BSel, ExtOp, ALUOp,
           InsnDone, Illegal
  );

  modport slave (
    output Op, Funct, Zero,
    input  PCWr, PCSrc, IRWr, MemWr, RFWr, RegDst, WDSel, BSel, ExtOp, ALUOp,
           InsnDone, Illegal
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle main control FSM (FETCH/DECODE/EXE/MEM/WB) for the MIPS-subset datapath.
// Optional MC_ILLEGAL_TRAP_EN: illegal opcodes park the FSM in HALT with a sticky Illegal flag.
module mc_ctrl (
  input  logic      clk,
  input  logic      rst,
  mc_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXE    = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_ILL, CL_ADDU, CL_SUBU, CL_ORI, CL_LUI, CL_LW, CL_SW, CL_BEQ, CL_J
  } cls_t;

  state_t     state;
  cls_t       cls_q;
  cls_t       cls_dec;

  logic       pc_wr, ir_wr, mem_wr, rf_wr, reg_dst, wd_sel, b_sel, insn_done;
  logic [1:0] pc_src, ext_op, alu_op;

  always_comb begin
    cls_dec = CL_ILL;
    case (bus.Op)
      6'b000000: begin
        if (bus.Funct == 6'b100001)      cls_dec = CL_ADDU;
        else if (bus.Funct == 6'b100011) cls_dec = CL_SUBU;
      end
      6'b001101: cls_dec = CL_ORI;
      6'b001111: cls_dec = CL_LUI;
      6'b100011: cls_dec = CL_LW;
      6'b101011: cls_dec = CL_SW;
      6'b000100: cls_dec = CL_BEQ;
      6'b000010: cls_dec = CL_J;
      default:   cls_dec = CL_ILL;
    endcase
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      cls_q <= CL_ILL;
`ifdef MC_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          cls_q <= cls_dec;
          case (cls_dec)
            CL_J: state <= FETCH;
            CL_ILL: begin
`ifdef MC_ILLEGAL_TRAP_EN
              state     <= HALT;
              illegal_q <= 1'b1;
`else
              state <= FETCH;
`endif
            end
            default: state <= EXE;
          endcase
        end
        EXE: begin
          case (cls_q)
            CL_ADDU, CL_SUBU, CL_ORI, CL_LUI: state <= WB;
            CL_LW, CL_SW:                     state <= MEM;
            default:                          state <= FETCH;
          endcase
        end
        MEM: state <= (cls_q == CL_LW) ? WB : FETCH;
        WB:  state <= FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
        HALT: state <= HALT;
`endif
        default: state <= FETCH;
      endcase
    end
  end

  // ALU controls are set in EXE and simply re-decoded from the latched class in MEM/WB.
  always_comb begin
    pc_wr     = 1'b0;
    pc_src    = '0;
    ir_wr     = 1'b0;
    mem_wr    = 1'b0;
    rf_wr     = 1'b0;
    reg_dst   = 1'b0;
    wd_sel    = 1'b0;
    b_sel     = 1'b0;
    ext_op    = '0;
    alu_op    = '0;
    insn_done = 1'b0;
    if (!rst) begin
      if (state == EXE || state == MEM || state == WB) begin
        case (cls_q)
          CL_SUBU:     alu_op = 2'b01;
          CL_ORI:      begin b_sel = 1'b1; alu_op = 2'b10; end
          CL_LUI:      begin b_sel = 1'b1; ext_op = 2'b10; alu_op = 2'b11; end
          CL_LW, CL_SW: begin b_sel = 1'b1; ext_op = 2'b01; end
          CL_BEQ:      alu_op = 2'b01;
          default:     alu_op = 2'b00;
        endcase
      end
      case (state)
        FETCH: begin
          ir_wr = 1'b1;
          pc_wr = 1'b1;
        end
        DECODE: begin
          case (cls_dec)
            CL_J: begin
              pc_wr     = 1'b1;
              pc_src    = 2'b10;
              insn_done = 1'b1;
            end
            CL_ILL: begin
`ifndef MC_ILLEGAL_TRAP_EN
              insn_done = 1'b1;
`endif
            end
            default: ;
          endcase
        end
        EXE: begin
          if (cls_q == CL_BEQ) begin
            pc_src    = 2'b01;
            pc_wr     = bus.Zero;
            insn_done = 1'b1;
          end
        end
        MEM: begin
          if (cls_q == CL_SW) begin
            mem_wr    = 1'b1;
            insn_done = 1'b1;
          end
        end
        WB: begin
          rf_wr     = 1'b1;
          insn_done = 1'b1;
          reg_dst   = (cls_q == CL_ADDU) || (cls_q == CL_SUBU);
          wd_sel    = (cls_q == CL_LW);
        end
        default: ;
      endcase
    end
  end

  assign bus.PCWr     = pc_wr;
  assign bus.PCSrc    = pc_src;
  assign bus.IRWr     = ir_wr;
  assign bus.MemWr    = mem_wr;
  assign bus.RFWr     = rf_wr;
  assign bus.RegDst   = reg_dst;
  assign bus.WDSel    = wd_sel;
  assign bus.BSel     = b_sel;
  assign bus.ExtOp    = ext_op;
  assign bus.ALUOp    = alu_op;
  assign bus.InsnDone = insn_done;
`ifdef MC_ILLEGAL_TRAP_EN
  assign bus.Illegal  = illegal_q & ~rst;
`else
  assign bus.Illegal  = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized self-checking bench for mc_ctrl against a per-instruction cycle-table model.
module tb_mc_ctrl;

  localparam int M_ADDU = 0, M_SUBU = 1, M_ORI = 2, M_LUI = 3, M_LW = 4,
                 M_SW = 5, M_BEQ = 6, M_J = 7, M_ILL = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  string names [9] = '{"addu", "subu", "ori", "lui", "lw", "sw", "beq", "j", "ill"};

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [14:0] obs;
  assign obs = {bus.PCWr, bus.PCSrc, bus.IRWr, bus.MemWr, bus.RFWr, bus.RegDst,
                bus.WDSel, bus.BSel, bus.ExtOp, bus.ALUOp, bus.InsnDone, bus.Illegal};

  task automatic check_eq(input string tag, input logic [14:0] got, input logic [14:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b (PCWr,PCSrc,IRWr,MemWr,RFWr,RegDst,WDSel,BSel,ExtOp,ALUOp,Done,Ill)",
               tag, got, exp);
    end
  endtask

  function automatic logic [14:0] mk(bit pcwr, bit [1:0] pcsrc, bit irwr, bit memwr, bit rfwr,
                                     bit regdst, bit wdsel, bit bsel, bit [1:0] ext,
                                     bit [1:0] alu, bit done, bit ill);
    return {pcwr, pcsrc, irwr, memwr, rfwr, regdst, wdsel, bsel, ext, alu, done, ill};
  endfunction

  function automatic int latency(int m);
    case (m)
      M_J, M_ILL: return 2;
      M_BEQ:      return 3;
      M_LW:       return 5;
      default:    return 4;
    endcase
  endfunction

  // Expected control vector in cycle k of instruction m (k=0 is FETCH).
  function automatic logic [14:0] exp_vec(int m, int k, bit z);
    bit       b;
    bit [1:0] e, a;
    b = 1'b0; e = 2'b00; a = 2'b00;
    case (m)
      M_SUBU:     a = 2'b01;
      M_ORI:      begin b = 1'b1; a = 2'b10; end
      M_LUI:      begin b = 1'b1; e = 2'b10; a = 2'b11; end
      M_LW, M_SW: begin b = 1'b1; e = 2'b01; end
      M_BEQ:      a = 2'b01;
      default:    ;
    endcase
    if (k == 0) return mk(1, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    if (k == 1) begin
      if (m == M_J) return mk(1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
`ifdef MC_ILLEGAL_TRAP_EN
      return '0;
`else
      if (m == M_ILL) return mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
      return '0;
`endif
    end
    if (m == M_BEQ) return mk(z, 2'b01, 0, 0, 0, 0, 0, b, e, a, 1, 0);
    if (m == M_SW && k == 3) return mk(0, 2'b00, 0, 1, 0, 0, 0, b, e, a, 1, 0);
    if (k == latency(m) - 1)
      return mk(0, 2'b00, 0, 0, 1, (m == M_ADDU || m == M_SUBU), (m == M_LW), b, e, a, 1, 0);
    return mk(0, 2'b00, 0, 0, 0, 0, 0, b, e, a, 0, 0);
  endfunction

  task automatic gen_insn(input int m, output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom);
    case (m)
      M_ADDU: begin op = 6'b000000; fn = 6'b100001; end
      M_SUBU: begin op = 6'b000000; fn = 6'b100011; end
      M_ORI:  op = 6'b001101;
      M_LUI:  op = 6'b001111;
      M_LW:   op = 6'b100011;
      M_SW:   op = 6'b101011;
      M_BEQ:  op = 6'b000100;
      M_J:    op = 6'b000010;
      default: begin
        if ($urandom_range(0, 1) == 0) begin
          op = 6'b000000;
          while (fn == 6'b100001 || fn == 6'b100011) fn = 6'($urandom);
        end else begin
          op = 6'($urandom);
          while (op == 6'b000000 || op == 6'b001101 || op == 6'b001111 || op == 6'b100011 ||
                 op == 6'b101011 || op == 6'b000100 || op == 6'b000010)
            op = 6'($urandom);
        end
      end
    endcase
  endtask

  // Called at posedge+1 of a FETCH cycle; returns at posedge+1 of the next FETCH cycle.
  task automatic run_insn(input int m, input int zf, input int rst_at, input logic [5:0] op_force);
    logic [5:0] op, fn;
    gen_insn(m, op, fn);
    if (op_force != 6'b000000) op = op_force;
    for (int k = 0; k < latency(m); k++) begin
      bus.Op    = (k == 0) ? 6'($urandom) : op;
      bus.Funct = (k == 0) ? 6'($urandom) : fn;
      bus.Zero  = (zf < 0) ? 1'($urandom) : zf[0];
      if (k == rst_at) rst = 1'b1;
      #3;
      if (rst) begin
        check_eq($sformatf("%s rst@k%0d", names[m], k), obs, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      check_eq($sformatf("%s k%0d", names[m], k), obs, exp_vec(m, k, bus.Zero));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.Op = '0;
    bus.Funct = '0;
    bus.Zero = 1'b0;
    @(posedge clk); #1;
    #3 check_eq("reset", obs, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_insn(M_ADDU, -1, -1, 6'b000000);
    run_insn(M_LW,   -1, -1, 6'b000000);
    run_insn(M_BEQ,   1, -1, 6'b000000);
    run_insn(M_BEQ,   0, -1, 6'b000000);
    run_insn(M_LUI,  -1, -1, 6'b000000);
    run_insn(M_ORI,  -1, -1, 6'b000000);
    run_insn(M_SUBU, -1, -1, 6'b000000);
    run_insn(M_J,    -1, -1, 6'b000000);
    run_insn(M_SW,   -1,  3, 6'b000000);
    run_insn(M_ADDU, -1, -1, 6'b000000);

`ifdef MC_ILLEGAL_TRAP_EN
    begin
      logic [5:0] op, fn;
      gen_insn(M_ILL, op, fn);
      op = 6'b111111;
      for (int k = 0; k < 14; k++) begin
        bus.Op    = (k == 0) ? 6'($urandom) : op;
        bus.Funct = (k == 0) ? 6'($urandom) : fn;
        bus.Zero  = 1'($urandom);
        #3;
        if (k < 2) check_eq($sformatf("ill k%0d", k), obs, exp_vec(M_ILL, k, bus.Zero));
        else       check_eq($sformatf("halt k%0d", k), obs, 15'b1);
        @(posedge clk); #1;
      end
      rst = 1'b1;
      #3 check_eq("halt rst", obs, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_insn(M_ORI, -1, -1, 6'b000000);
    end
`else
    run_insn(M_ILL, -1, -1, 6'b111111);
    run_insn(M_ILL, -1, -1, 6'b000000);
`endif

    for (int i = 0; i < 400; i++) begin
      int m, ra;
`ifdef MC_ILLEGAL_TRAP_EN
      m = $urandom_range(0, 7);
`else
      m = $urandom_range(0, 8);
`endif
      ra = ($urandom_range(0, 15) == 0) ? $urandom_range(0, latency(m) - 1) : -1;
      run_insn(m, -1, ra, 6'b000000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
